square_stream_checker: RTL

Downstream monitor for the 64-entry square-table stream generator. It samples the 12-bit square stream and locks onto the sequence at the 0 entry. It then regenerates the expected value incrementally, without a multiplier, and flags and counts mismatches. It drops lock after repeated misses and re-acquires on the next 0 entry. It sits on the generator's output bus and exposes status to the test harness or a debug register block.

---
 rtl/square_stream_checker_if.sv | 24 ++
 rtl/square_stream_checker.sv | 116 +++++++++++
 2 files changed

// File: rtl/square_stream_checker_if.sv
// Bus between the square-table generator / test harness and the stream checker.
// The generator side drives the sample and clear; the checker side drives the status.
interface square_stream_checker_if #(
  parameter int unsigned ERR_W = 16
);
  logic             in_valid;
  logic [11:0]      square_in;
  logic             clear_err;
  logic             locked;
  logic [5:0]       index;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic             wrap_pulse;

  modport master (
    output in_valid, square_in, clear_err,
    input  locked, index, err_pulse, err_count, wrap_pulse
  );

  modport slave (
    input  in_valid, square_in, clear_err,
    output locked, index, err_pulse, err_count, wrap_pulse
  );
endinterface

// File: rtl/square_stream_checker.sv
// Locks onto the n*n (n = 0..63) square stream at its 0 entry, regenerates the
// expected squares incrementally and flags, counts and tolerates mismatches.
module square_stream_checker #(
  parameter int unsigned MISS_LIMIT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input logic                    CLK,
  input logic                    RST,
  square_stream_checker_if.slave mon
);

  typedef enum logic [0:0] {StSearch, StTrack} state_e;

  localparam logic [3:0] MissLimit = 4'(MISS_LIMIT);

  state_e           r_state,     w_state_d;
  logic [5:0]       r_exp_idx,   w_exp_idx_d;
  logic [11:0]      r_exp_sq,    w_exp_sq_d;
  logic [3:0]       r_miss_cnt,  w_miss_cnt_d;
  logic [5:0]       r_index,     w_index_d;
  logic             r_err_pulse, w_err_pulse_d;
  logic [ERR_W-1:0] r_err_cnt,   w_err_cnt_d;
  logic             r_wrap,      w_wrap_d;

  logic             w_match;
  logic             w_last_idx;
  logic [12:0]      w_sq_sum;
  logic [3:0]       w_miss_inc;

  assign w_match    = (mon.square_in == r_exp_sq);
  assign w_last_idx = (r_exp_idx == 6'd63);
  // (n+1)^2 = n^2 + 2n + 1; {n, 1'b1} is 2n+1.
  assign w_sq_sum   = {1'b0, r_exp_sq} + {6'd0, r_exp_idx, 1'b1};
  assign w_miss_inc = r_miss_cnt + 4'd1;

  always_comb begin
    w_state_d     = r_state;
    w_exp_idx_d   = r_exp_idx;
    w_exp_sq_d    = r_exp_sq;
    w_miss_cnt_d  = r_miss_cnt;
    w_index_d     = r_index;
    w_err_pulse_d = 1'b0;
    w_err_cnt_d   = r_err_cnt;
    w_wrap_d      = 1'b0;

    if (mon.in_valid) begin
      unique case (r_state)
        StSearch: begin
          if (mon.square_in == 12'd0) begin
            w_state_d    = StTrack;
            w_index_d    = 6'd0;
            w_exp_idx_d  = 6'd1;
            w_exp_sq_d   = 12'd1;
            w_miss_cnt_d = 4'd0;
          end
        end
        StTrack: begin
          // Expectation advances on every sample; the stream keeps counting under corruption.
          w_exp_idx_d = r_exp_idx + 6'd1;
          w_exp_sq_d  = (w_last_idx || w_sq_sum[12]) ? 12'd0 : w_sq_sum[11:0];
          w_index_d   = r_exp_idx;
          if (w_match) begin
            w_miss_cnt_d = 4'd0;
            w_wrap_d     = w_last_idx;
          end else begin
            w_err_pulse_d = 1'b1;
            if (r_err_cnt != {ERR_W{1'b1}}) begin
              w_err_cnt_d = r_err_cnt + ERR_W'(1);
            end
            if (w_miss_inc == MissLimit) begin
              w_state_d    = StSearch;
              w_index_d    = 6'd0;
              w_miss_cnt_d = 4'd0;
            end else begin
              w_miss_cnt_d = w_miss_inc;
            end
          end
        end
        default: w_state_d = StSearch;
      endcase
    end

    if (mon.clear_err) begin
      w_err_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StSearch;
      r_exp_idx   <= 6'd0;
      r_exp_sq    <= 12'd0;
      r_miss_cnt  <= 4'd0;
      r_index     <= 6'd0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_exp_idx   <= w_exp_idx_d;
      r_exp_sq    <= w_exp_sq_d;
      r_miss_cnt  <= w_miss_cnt_d;
      r_index     <= w_index_d;
      r_err_pulse <= w_err_pulse_d;
      r_err_cnt   <= w_err_cnt_d;
      r_wrap      <= w_wrap_d;
    end
  end

  assign mon.locked     = (r_state == StTrack);
  assign mon.index      = r_index;
  assign mon.err_pulse  = r_err_pulse;
  assign mon.err_count  = r_err_cnt;
  assign mon.wrap_pulse = r_wrap;

endmodule
